// File: rtl/uart_rx_pkg.sv
// Shared types and register layout for the UART receiver device.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    localparam logic [3:0] RX_DATA_OFFSET   = 4'h0;
    localparam logic [3:0] RX_STATUS_OFFSET = 4'h4;

    localparam int STATUS_NOT_EMPTY = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERRUN   = 2;
    localparam int STATUS_FRAME_ERR = 3;
    localparam int STATUS_LEVEL_LSB = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a combinational head; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module rx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(Depth));
    assign level   = count_q;
    assign rdata   = mem[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver bus device: synchronizer, receive FSM, byte FIFO and
// RXDATA/STATUS registers with a level interrupt while data is pending.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        rx_irq_o
);
    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int HalfBit      = ClocksPerBit / 2;
    localparam int CntW         = $clog2(ClocksPerBit);
    localparam int LvlW         = $clog2(FifoDepth) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);

    logic [1:0]      sync_q;
    logic            rx_line;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_done, frame_err_set;

    logic            fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_rdata;
    logic [LvlW-1:0] fifo_level;

    logic            overrun_q, frame_err_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d, status_word;
    logic            is_data, is_status, rd_req, w1c_req;
    logic            overrun_set, overrun_clr, frame_err_clr;
    logic            unused_bus;

    assign rx_line = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], uart_rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_done     = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_line) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_line, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_line) begin
                        byte_done = 1'b1;
                        state_d   = RX_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Holding here keeps a break (line stuck low) from producing frames.
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_line) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (byte_done),
        .wdata (shift_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign is_data       = (device_addr_i[3:2] == RX_DATA_OFFSET[3:2]);
    assign is_status     = (device_addr_i[3:2] == RX_STATUS_OFFSET[3:2]);
    assign rd_req        = device_req_i && !device_we_i;
    assign w1c_req       = device_req_i && device_we_i && is_status;
    assign fifo_pop      = rd_req && is_data && !fifo_empty;
    assign overrun_set   = byte_done && fifo_full && !fifo_pop;
    assign overrun_clr   = w1c_req && device_wdata_i[STATUS_OVERRUN];
    assign frame_err_clr = w1c_req && device_wdata_i[STATUS_FRAME_ERR];
    assign unused_bus    = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                             device_wdata_i[31:4], device_wdata_i[1:0]};

    always_comb begin
        status_word = '0;
        status_word[STATUS_NOT_EMPTY] = !fifo_empty;
        status_word[STATUS_FULL]      = fifo_full;
        status_word[STATUS_OVERRUN]   = overrun_q;
        status_word[STATUS_FRAME_ERR] = frame_err_q;
        status_word[STATUS_LEVEL_LSB +: LvlW] = fifo_level;
    end

    always_comb begin
        rdata_d = '0;
        if (rd_req && is_data && !fifo_empty) rdata_d = {24'b0, fifo_rdata};
        else if (rd_req && is_status)         rdata_d = status_word;
    end

    // Sticky flags: a set in the same cycle as its clear takes priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            overrun_q   <= overrun_set   || (overrun_q   && !overrun_clr);
            frame_err_q <= frame_err_set || (frame_err_q && !frame_err_clr);
            rvalid_q    <= device_req_i;
            rdata_q     <= rdata_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign rx_irq_o        = !fifo_empty;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver bus device, the receive counterpart of the system's transmit-only UART. It samples an asynchronous 8N1 serial input, assembles bytes into an 8-entry receive FIFO and exposes data and status registers on the system bus device port. It drives a level interrupt while received data is pending. It sits on the system bus beside the existing UART TX device at its own 4 KiB window.

## Interface
- ClockFrequency, 50_000_000: system clock frequency in Hz.
- BaudRate, 115_200: serial bit rate.
- FifoDepth, 8: receive FIFO entries; power of two, at least 2.
- clk_i  in  1  system clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- device_req_i  in  1  bus request; every request is accepted.
- device_addr_i  in  32  byte address; only bits [3:2] are decoded.
- device_we_i  in  1  write enable.
- device_be_i  in  4  byte enables; ignored, accesses are full-word.
- device_wdata_i  in  32  write data.
- device_rvalid_o  out  1  response valid.
- device_rdata_o  out  32  read data.
- uart_rx_i  in  1  asynchronous serial input; idles high.
- rx_irq_o  out  1  high while the FIFO is non-empty.

## Operation
- ClocksPerBit = ClockFrequency / BaudRate, using integer division. HalfBit = ClocksPerBit / 2.
- The input passes through a 2-flop synchronizer. The synchronizer resets to 1.
- Receive FSM, sampling the synchronized line:
  - Idle: line low -> Start; counter cleared.
  - Start: at counter == HalfBit-1, sample. Low -> Data with counter and bit index cleared. High -> Idle (glitch rejected).
  - Data: at counter == ClocksPerBit-1, sample into the shift register, LSB first. After bit 7 -> Stop.
  - Stop: at counter == ClocksPerBit-1, sample. High -> push the byte, then Idle. Low -> set frame_err, drop the byte, then WaitHigh.
  - WaitHigh: line high -> Idle. This state blocks break conditions from generating frames.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overrun is set.
- Register map:
  - 0x0 RXDATA (read): returns {24'b0, head byte} and pops the head. When the FIFO is empty it returns 0 with no pop and no underflow. Writes are ignored.
  - 0x4 STATUS (read): bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bits[11:8] level, other bits 0.
  - 0x4 STATUS (write): writing 1 to bit2 or bit3 clears that flag (W1C).
  - 0x8 and 0xC: read 0; writes are ignored.
- If a sticky-flag set and its W1C clear happen in the same cycle, the set wins.
- rx_irq_o = not_empty, taken from the registered FIFO count.

## Timing
- Bus:
  - device_rvalid_o is asserted exactly one cycle after every device_req_i, for both reads and writes.
  - device_rdata_o is registered and is valid in the rvalid cycle; it is 0 on writes.
  - The pop takes effect in the cycle the request is sampled.
- Receive latency: the synchronizer adds 2 cycles. The byte is visible in the FIFO (not_empty=1, rx_irq_o=1) in the cycle after the stop-bit sample.
- Back-to-back reads: each read returns successive entries with no bubble.
- Reset (rst_i sampled high):
  - FSM -> Idle; counter, bit index and shift register cleared.
  - FIFO emptied; overrun=0; frame_err=0.
  - device_rvalid_o=0, device_rdata_o=0, rx_irq_o=0.
  - A frame in flight is discarded.
- Counter width is $clog2(ClocksPerBit). The counter never wraps past ClocksPerBit-1.

## Structure
- uart_rx_pkg holds:
  - the FSM state enum (Idle, Start, Data, Stop, WaitHigh);
  - register offsets RX_DATA_OFFSET=0x0 and RX_STATUS_OFFSET=0x4;
  - STATUS bit positions.
- Sub-module rx_fifo (sync FIFO, parameters Depth and Width) provides:
  - push, pop, rdata (head, combinational), full, empty, level;
  - synchronous active-high reset.
- The FSM, synchronizer and register logic live in uart_rx itself.

## Test plan
All scenarios use ClockFrequency=1_600_000 and BaudRate=100_000, giving ClocksPerBit=16.
- Frame 0xA5:
  - STATUS reads 0x101 and rx_irq_o=1.
  - RXDATA returns 0x000000A5.
  - STATUS then reads 0x000 and rx_irq_o=0.
- 6-cycle low glitch on an idle line -> STATUS stays 0x000 and the FSM returns to Idle.
- Frame 0x3C with the stop bit low:
  - STATUS bit3 set, FIFO empty.
  - The FSM stays in WaitHigh until the line rises.
  - Writing 0x8 to STATUS clears it to 0x000.
- Nine frames 0x01..0x09 with no reads:
  - After the 8th, STATUS reads 0x803.
  - After the 9th, it reads 0x807.
  - Eight reads return 0x01..0x08 in order, then an empty read returns 0.
- rst_i pulsed mid-frame during Data:
  - STATUS reads 0x000.
  - A following frame 0x5A is received intact.
- RXDATA read on an empty FIFO -> rdata 0, rvalid one cycle later, level stays 0.
- Same-cycle overrun set and W1C clear -> overrun stays 1.
